// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
// Drives a fetch address with a valid/ready handshake. Redirects come from
// jtag reset, trap and jump in that priority order. A redirect arriving while
// a fetch is outstanding is buffered (latest wins) and applied after accept.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   jtag_reset_flag_i        synchronous soft reset back to RESET_VEC / BOOT
//   trap_flag_i/trap_addr_i  trap redirect request and target
//   jump_flag_i/jump_addr_i  jump redirect request and target
//   hold_flag_i              pipeline hold, any nonzero value holds
//   fetch_ready_i            instruction memory accepts pc_o this cycle
//   pc_o, pc_valid_o         fetch address and request valid
//   redirect_o               pulse: pc_o loaded from a redirect
//   misalign_o               pulse: misaligned target was corrected
//
// Optional feature macro: PC_MISALIGN_CHK_EN (align redirect targets to STEP).
module pc_gen #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned     STEP      = 4,
  parameter int unsigned     HOLD_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_reset_flag_i,
  input  logic              trap_flag_i,
  input  logic [PC_W-1:0]   trap_addr_i,
  input  logic              jump_flag_i,
  input  logic [PC_W-1:0]   jump_addr_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              fetch_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              pc_valid_o,
  output logic              redirect_o,
  output logic              misalign_o
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_valid;
  logic            r_redirect;
  logic            r_misalign;
  logic            r_pend_v;
  logic [PC_W-1:0] r_pend_addr;

  logic [0:0]      w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_valid_nxt;
  logic            w_redirect_nxt;
  logic            w_misalign_nxt;
  logic            w_pend_v_nxt;
  logic [PC_W-1:0] w_pend_addr_nxt;

  logic            w_outst;
  logic            w_acc;
  logic            w_req;
  logic            w_hold;
  logic [PC_W-1:0] w_ta;
  logic [PC_W-1:0] w_load_src;
  logic [PC_W-1:0] w_load_addr;
  logic            w_load_mis;

  assign w_outst    = r_valid & ~fetch_ready_i;
  assign w_acc      = r_valid & fetch_ready_i;
  assign w_req      = trap_flag_i | jump_flag_i;
  assign w_hold     = |hold_flag_i;
  assign w_ta       = trap_flag_i ? trap_addr_i : jump_addr_i;
  // A fresh redirect takes precedence over a buffered one.
  assign w_load_src = w_req ? w_ta : r_pend_addr;

`ifdef PC_MISALIGN_CHK_EN
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);
  assign w_load_addr = w_load_src & ~ALIGN_MASK;
  assign w_load_mis  = |(w_load_src & ALIGN_MASK);
`else
  assign w_load_addr = w_load_src;
  assign w_load_mis  = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= BOOT;
      r_pc        <= RESET_VEC;
      r_valid     <= 1'b0;
      r_redirect  <= 1'b0;
      r_misalign  <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_valid     <= w_valid_nxt;
      r_redirect  <= w_redirect_nxt;
      r_misalign  <= w_misalign_nxt;
      r_pend_v    <= w_pend_v_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end

  // Next-state logic: fixed-priority redirect / hold / sequential advance.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_valid_nxt     = r_valid;
    w_redirect_nxt  = 1'b0;
    w_misalign_nxt  = 1'b0;
    w_pend_v_nxt    = r_pend_v;
    w_pend_addr_nxt = r_pend_addr;

    if (jtag_reset_flag_i) begin
      w_state_nxt  = BOOT;
      w_pc_nxt     = RESET_VEC;
      w_valid_nxt  = 1'b0;
      w_pend_v_nxt = 1'b0;
    end else begin
      w_state_nxt = RUN;
      if (w_outst) begin
        // Request must stay stable; remember the redirect for later.
        if (w_req) begin
          w_pend_addr_nxt = w_ta;
          w_pend_v_nxt    = 1'b1;
        end
      end else begin
        w_valid_nxt = (r_state == RUN) & ~w_hold;
        if (w_req || r_pend_v) begin
          w_pc_nxt       = w_load_addr;
          w_redirect_nxt = 1'b1;
          w_misalign_nxt = w_load_mis;
          w_pend_v_nxt   = 1'b0;
        end else if (!w_hold && w_acc) begin
          w_pc_nxt = r_pc + PC_W'(STEP);
        end
      end
    end
  end

  assign pc_o       = r_pc;
  assign pc_valid_o = r_valid;
  assign redirect_o = r_redirect;
  assign misalign_o = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with an abstract reference model and per-cycle compare.
module tb_pc_gen;
  localparam int unsigned PC_W   = 32;
  localparam logic [31:0] RVEC   = 32'h100;
  localparam int unsigned STEP   = 4;
  localparam int unsigned HOLD_W = 3;

  logic              clk;
  logic              rst;
  logic              jtag;
  logic              trap;
  logic [PC_W-1:0]   trap_addr;
  logic              jump;
  logic [PC_W-1:0]   jump_addr;
  logic [HOLD_W-1:0] hold;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic              valid;
  logic              redir;
  logic              mis;

  int checks = 0;
  int errors = 0;

  pc_gen #(.PC_W(PC_W), .RESET_VEC(RVEC), .STEP(STEP), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .jtag_reset_flag_i(jtag),
    .trap_flag_i(trap), .trap_addr_i(trap_addr),
    .jump_flag_i(jump), .jump_addr_i(jump_addr),
    .hold_flag_i(hold), .fetch_ready_i(ready),
    .pc_o(pc), .pc_valid_o(valid), .redirect_o(redir), .misalign_o(mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected outputs after each clock, from the behavioural rules.
  logic [31:0] m_pc;
  logic        m_valid, m_red, m_mis, m_pend_v, m_booting;
  logic [31:0] m_pend_a;
  logic [31:0] src;
  logic        load, busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = RVEC; m_valid = 0; m_red = 0; m_mis = 0;
      m_pend_v = 0; m_pend_a = 0; m_booting = 1;
    end else begin
      m_red = 0; m_mis = 0;
      busy = m_valid && !ready;
      if (jtag) begin
        m_pc = RVEC; m_valid = 0; m_pend_v = 0; m_booting = 1;
      end else if (busy) begin
        if (trap || jump) begin
          m_pend_a = trap ? trap_addr : jump_addr;
          m_pend_v = 1;
        end
      end else begin
        load = 0; src = 0;
        if (trap || jump) begin load = 1; src = trap ? trap_addr : jump_addr; end
        else if (m_pend_v) begin load = 1; src = m_pend_a; end
        if (load) begin
          m_pend_v = 0;
          m_red = 1;
`ifdef PC_MISALIGN_CHK_EN
          m_mis = (src % STEP) != 0;
          m_pc  = src - (src % STEP);
`else
          m_pc  = src;
`endif
        end else if (hold == 0 && m_valid && ready) begin
          m_pc = m_pc + STEP;
        end
        m_valid   = !m_booting && (hold == 0);
        m_booting = 0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    checks++;
    if (pc !== m_pc || valid !== m_valid || redir !== m_red || mis !== m_mis) begin
      errors++;
      $display("FAIL model_cmp t=%0t got pc=%h v=%b r=%b m=%b exp pc=%h v=%b r=%b m=%b",
               $time, pc, valid, redir, mis, m_pc, m_valid, m_red, m_mis);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_jump(input logic [31:0] a);
    jump = 1; jump_addr = a; step(); jump = 0;
  endtask

  initial begin
    rst = 0; jtag = 0; trap = 0; trap_addr = 0; jump = 0; jump_addr = 0;
    hold = 0; ready = 1;
    step(); step();
    chk("rst_pc", pc, 32'h100);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_redir", {31'b0, redir}, 32'h0);
    rst = 1;
    step();
    chk("boot_valid", {31'b0, valid}, 32'h0);
    step();
    chk("run_pc0", pc, 32'h100);
    chk("run_valid", {31'b0, valid}, 32'h1);
    step(); chk("run_pc1", pc, 32'h104);
    step(); chk("run_pc2", pc, 32'h108);

    // Plain jump.
    do_jump(32'h2000);
    chk("jump_pc", pc, 32'h2000);
    chk("jump_redir", {31'b0, redir}, 32'h1);
    step();
    chk("jump_redir_clr", {31'b0, redir}, 32'h0);
    chk("jump_seq", pc, 32'h2004);

    // Redirect during an outstanding fetch is deferred.
    do_jump(32'h40);
    ready = 0; step();
    chk("outst_pc", pc, 32'h40);
    do_jump(32'h800);
    chk("outst_hold_pc", pc, 32'h40);
    chk("outst_no_redir", {31'b0, redir}, 32'h0);
    ready = 1; step();
    chk("pend_pc", pc, 32'h800);
    chk("pend_redir", {31'b0, redir}, 32'h1);
    step();

    // Trap beats jump, and the load still obeys hold.
    trap = 1; trap_addr = 32'h300; jump = 1; jump_addr = 32'h500; hold = 3'b010;
    step();
    trap = 0; jump = 0;
    chk("trap_pc", pc, 32'h300);
    chk("trap_valid", {31'b0, valid}, 32'h0);
    step();
    chk("hold_pc", pc, 32'h300);
    chk("hold_valid", {31'b0, valid}, 32'h0);
    hold = 0; step();
    chk("unhold_valid", {31'b0, valid}, 32'h1);
    chk("unhold_pc", pc, 32'h300);

    // Wrap at the top of the address space.
    do_jump(32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc, 32'h0);

    // Jtag reset during an outstanding fetch drops the pending redirect.
    ready = 0; step();
    do_jump(32'h777);
    jtag = 1; step(); jtag = 0;
    chk("jtag_pc", pc, 32'h100);
    chk("jtag_valid", {31'b0, valid}, 32'h0);
    ready = 1; step();
    chk("jtag_boot_valid", {31'b0, valid}, 32'h0);
    step();
    chk("jtag_pend_clr", pc, 32'h100);
    chk("jtag_run_valid", {31'b0, valid}, 32'h1);

    // Misaligned target handling.
    do_jump(32'h1002);
`ifdef PC_MISALIGN_CHK_EN
    chk("mis_pc", pc, 32'h1000);
    chk("mis_flag", {31'b0, mis}, 32'h1);
`else
    chk("mis_pc", pc, 32'h1002);
    chk("mis_flag", {31'b0, mis}, 32'h0);
`endif
    step();
    chk("mis_clr", {31'b0, mis}, 32'h0);

    // Short mixed pattern for the model compare.
    for (int i = 0; i < 12; i++) begin
      ready = (i % 3) != 1;
      hold  = (i == 5) ? 3'b100 : 3'b000;
      jump  = (i == 2) || (i == 7);
      jump_addr = 32'h4000 + 32'(i * 16);
      step();
    end
    jump = 0; step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
